// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices, FSM encoding,
// register-address width and the stall/flush patterns built from them.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned NumStages = 4;

    localparam int unsigned StageIfId  = 0;
    localparam int unsigned StageIdEx  = 1;
    localparam int unsigned StageExMem = 2;
    localparam int unsigned StageMemWb = 3;

    typedef enum logic {
        StIdle = 1'b0,
        StMcyc = 1'b1
    } hz_state_e;

    typedef logic [RegAddrW-1:0]  reg_addr_t;
    typedef logic [NumStages-1:0] stage_vec_t;

    localparam stage_vec_t StageNone = '0;
    localparam stage_vec_t StageAll  = '1;

    // Per-hazard stall/flush patterns, expressed in terms of the stage indices.
    localparam stage_vec_t StallMcyc    = (stage_vec_t'(1) << StageIfId) |
                                          (stage_vec_t'(1) << StageIdEx);
    localparam stage_vec_t FlushMcyc    = stage_vec_t'(1) << StageExMem;
    localparam stage_vec_t FlushBranch  = (stage_vec_t'(1) << StageIfId) |
                                          (stage_vec_t'(1) << StageIdEx);
    localparam stage_vec_t StallLoadUse = stage_vec_t'(1) << StageIfId;
    localparam stage_vec_t FlushLoadUse = stage_vec_t'(1) << StageIdEx;

    function automatic logic src_hit(input reg_addr_t src, input logic ren,
                                     input reg_addr_t rd);
        return ren && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mcyc_counter.sv
// Multi-cycle EX op tracker: IDLE/MCYC state flop plus a down-counter that
// keeps running regardless of memory wait.
module pipe_hazard_ctrl_mcyc_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MCYC_LAT = 4,
    parameter int unsigned CNT_W    = $clog2(MCYC_LAT) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;

    // The start cycle is served from IDLE, so MCYC only needs MCYC_LAT-1 more.
    assign done = (state_q == StMcyc) && (cnt_q == CNT_W'(1));
    assign busy = (state_q == StMcyc);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StMcyc;
                    cnt_d   = CNT_W'(MCYC_LAT - 1);
                end
            end
            StMcyc: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (done) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for the 5-stage pipeline. Optional performance
// counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MCYC_LAT = 4,
    parameter int unsigned CNT_W    = $clog2(MCYC_LAT) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RegAddrW-1:0]  id_rs1_addr,
    input  logic [RegAddrW-1:0]  id_rs2_addr,
    input  logic                 id_rs1_ren,
    input  logic                 id_rs2_ren,
    input  logic [RegAddrW-1:0]  ex_rd_addr,
    input  logic                 ex_mem_ren,
    input  logic                 ex_branch_taken,
    input  logic [XLEN-1:0]      ex_branch_target,
    input  logic                 ex_mcyc_start,
    input  logic                 mem_wait,
    output logic                 pc_stall,
    output logic                 pc_redirect,
    output logic [XLEN-1:0]      pc_redirect_addr,
    output logic [NumStages-1:0] stall,
    output logic [NumStages-1:0] flush,
    output logic                 mcyc_busy,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
);

    logic busy;
    logic mcyc_load;
    logic mcyc_hold;
    logic load_use;

    // A start held off by mem_wait is not latched; the op stays in EX and re-asserts.
    assign mcyc_load = ex_mcyc_start && !mem_wait && !busy;
    assign mcyc_hold = busy || ex_mcyc_start;

    assign load_use = ex_mem_ren && (ex_rd_addr != '0) &&
                      (src_hit(id_rs1_addr, id_rs1_ren, ex_rd_addr) ||
                       src_hit(id_rs2_addr, id_rs2_ren, ex_rd_addr));

    pipe_hazard_ctrl_mcyc_counter #(
        .MCYC_LAT (MCYC_LAT),
        .CNT_W    (CNT_W)
    ) u_mcyc_counter (
        .clk  (clk),
        .rst  (rst),
        .load (mcyc_load),
        .busy (busy)
    );

    assign mcyc_busy = rst && busy;

    always_comb begin
        pc_stall         = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = '0;
        stall            = StageNone;
        flush            = StageNone;
        if (!rst) begin
            // Outputs held quiet while in reset.
        end else if (mem_wait) begin
            pc_stall = 1'b1;
            stall    = StageAll;
        end else if (mcyc_hold) begin
            pc_stall = 1'b1;
            stall    = StallMcyc;
            flush    = FlushMcyc;
        end else if (ex_branch_taken) begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = ex_branch_target;
            flush            = FlushBranch;
        end else if (load_use) begin
            pc_stall = 1'b1;
            stall    = StallLoadUse;
            flush    = FlushLoadUse;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush != StageNone) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = rst ? perf_stall_q : '0;
    assign perf_flush_cnt = rst ? perf_flush_q : '0;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences and
// randomized cycles against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned LAT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_ren, id_rs2_ren, ex_mem_ren;
    logic        ex_branch_taken, ex_mcyc_start, mem_wait;
    logic [31:0] ex_branch_target;
    logic        pc_stall, pc_redirect, mcyc_busy;
    logic [31:0] pc_redirect_addr, perf_stall_cnt, perf_flush_cnt;
    logic [3:0]  stall, flush;

    pipe_hazard_ctrl #(
        .XLEN     (XLEN),
        .MCYC_LAT (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs2_addr      (id_rs2_addr),
        .id_rs1_ren       (id_rs1_ren),
        .id_rs2_ren       (id_rs2_ren),
        .ex_rd_addr       (ex_rd_addr),
        .ex_mem_ren       (ex_mem_ren),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .ex_mcyc_start    (ex_mcyc_start),
        .mem_wait         (mem_wait),
        .pc_stall         (pc_stall),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .stall            (stall),
        .flush            (flush),
        .mcyc_busy        (mcyc_busy),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_flush_cnt   (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected values for the current cycle.
    logic        exp_pcs, exp_red, exp_busy;
    logic [31:0] exp_addr, exp_pstall, exp_pflush;
    logic [3:0]  exp_st, exp_fl;
    bit          perf_chk_en = 1'b0;

    // Reference model: cycles elapsed since the multi-cycle op started (0 = none).
    int          age = 0;
    int unsigned m_stall_cnt = 0, m_flush_cnt = 0;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        r1en, r2en;
        logic [4:0]  rd;
        logic        load, taken;
        logic [31:0] tgt;
        logic        start, mw;
        logic        e_pcs, e_red;
        logic [31:0] e_addr;
        logic [3:0]  e_st, e_fl;
    } vec_t;

    vec_t vecs[9];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic idle_in();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; ex_mem_ren = 1'b0;
        ex_branch_taken = 1'b0; ex_branch_target = 32'd0;
        ex_mcyc_start = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic set_exp(input logic pcs, input logic red, input logic [31:0] addr,
                           input logic [3:0] st, input logic [3:0] fl, input logic busy);
        exp_pcs = pcs; exp_red = red; exp_addr = addr;
        exp_st = st; exp_fl = fl; exp_busy = busy;
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task automatic check_cycle(input string nm);
        @(negedge clk);
        cmp({nm, ".pc_stall"}, 64'(pc_stall), 64'(exp_pcs));
        cmp({nm, ".pc_redirect"}, 64'(pc_redirect), 64'(exp_red));
        cmp({nm, ".redirect_addr"}, 64'(pc_redirect_addr), 64'(exp_addr));
        cmp({nm, ".stall"}, 64'(stall), 64'(exp_st));
        cmp({nm, ".flush"}, 64'(flush), 64'(exp_fl));
        cmp({nm, ".mcyc_busy"}, 64'(mcyc_busy), 64'(exp_busy));
        if (perf_chk_en) begin
            cmp({nm, ".perf_stall"}, 64'(perf_stall_cnt), 64'(exp_pstall));
            cmp({nm, ".perf_flush"}, 64'(perf_flush_cnt), 64'(exp_pflush));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_eval();
        logic lu, mc;
        lu = ex_mem_ren && (ex_rd_addr != 5'd0) &&
             ((id_rs1_ren && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_ren && id_rs2_addr == ex_rd_addr));
        mc = (age > 0) || ex_mcyc_start;
        set_exp(1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000, rst && (age > 0));
        if (!rst) begin
            exp_busy = 1'b0;
        end else if (mem_wait) begin
            exp_pcs = 1'b1; exp_st = 4'b1111;
        end else if (mc) begin
            exp_pcs = 1'b1; exp_st = 4'b0011; exp_fl = 4'b0100;
        end else if (ex_branch_taken) begin
            exp_red = 1'b1; exp_addr = ex_branch_target; exp_fl = 4'b0011;
        end else if (lu) begin
            exp_pcs = 1'b1; exp_st = 4'b0001; exp_fl = 4'b0010;
        end
`ifdef PIPE_HAZARD_PERF_EN
        exp_pstall = rst ? m_stall_cnt : 32'd0;
        exp_pflush = rst ? m_flush_cnt : 32'd0;
`else
        exp_pstall = 32'd0;
        exp_pflush = 32'd0;
`endif
    endtask

    task automatic model_tick();
        if (!rst) begin
            age = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (exp_pcs) m_stall_cnt++;
            if (exp_fl != 4'b0000) m_flush_cnt++;
            if (age > 0) begin
                age++;
                if (age == LAT) age = 0;
            end else if (ex_mcyc_start && !mem_wait) begin
                age = 1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000};
        vecs[1] = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b1, 1'b0, 32'h0, 4'b0001, 4'b0010};
        vecs[2] = '{5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000};
        vecs[3] = '{5'd4, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000};
        vecs[4] = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1,
                    1'b1, 1'b0, 32'h0, 4'b1111, 4'b0000};
        vecs[5] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h44, 1'b1, 1'b1,
                    1'b1, 1'b0, 32'h0, 4'b1111, 4'b0000};
        vecs[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'h1234_5678, 4'b0000, 4'b0011};
        vecs[7] = '{5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 32'h8000_0040, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'h8000_0040, 4'b0000, 4'b0011};
        vecs[8] = '{5'd11, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000};

        // Reset with hazards asserted: everything quiet.
        idle_in();
        rst = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 32'hdead_beef;
        mem_wait = 1'b1; ex_mcyc_start = 1'b1;
        set_exp(1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0);
        check_cycle("rst0");
        check_cycle("rst1");
        cmp("rst.perf_stall", 64'(perf_stall_cnt), 64'd0);
        cmp("rst.perf_flush", 64'(perf_flush_cnt), 64'd0);
        rst = 1'b1; idle_in();
        check_cycle("post_rst0");
        check_cycle("post_rst1");

        // Clean multi-cycle op: four frozen cycles, busy on the last three.
        ex_mcyc_start = 1'b1;
        set_exp(1'b1, 1'b0, 32'd0, 4'b0011, 4'b0100, 1'b0);
        check_cycle("mcyc_c1");
        ex_mcyc_start = 1'b0;
        set_exp(1'b1, 1'b0, 32'd0, 4'b0011, 4'b0100, 1'b1);
        for (int c = 2; c <= 4; c++) check_cycle($sformatf("mcyc_c%0d", c));
        set_exp(1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0);
        check_cycle("mcyc_c5");
`ifdef PIPE_HAZARD_PERF_EN
        cmp("perf_stall_after_mcyc", 64'(perf_stall_cnt), 64'd4);
        cmp("perf_flush_after_mcyc", 64'(perf_flush_cnt), 64'd4);
`else
        cmp("perf_stall_after_mcyc", 64'(perf_stall_cnt), 64'd0);
        cmp("perf_flush_after_mcyc", 64'(perf_flush_cnt), 64'd0);
`endif

        // mem_wait inside MCYC, branch held back until the bus is free.
        ex_mcyc_start = 1'b1;
        set_exp(1'b1, 1'b0, 32'd0, 4'b0011, 4'b0100, 1'b0);
        check_cycle("mw_c1");
        ex_mcyc_start = 1'b0; mem_wait = 1'b1;
        set_exp(1'b1, 1'b0, 32'd0, 4'b1111, 4'b0000, 1'b1);
        check_cycle("mw_c2");
        ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_2000;
        check_cycle("mw_c3");
        check_cycle("mw_c4");
        mem_wait = 1'b0;
        set_exp(1'b0, 1'b1, 32'h0000_2000, 4'b0000, 4'b0011, 1'b0);
        check_cycle("mw_c5_branch");
        idle_in();
        set_exp(1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0);
        check_cycle("mw_c6");

        // Reset in the middle of MCYC releases everything.
        ex_mcyc_start = 1'b1;
        set_exp(1'b1, 1'b0, 32'd0, 4'b0011, 4'b0100, 1'b0);
        check_cycle("mrst_c1");
        ex_mcyc_start = 1'b0; rst = 1'b0;
        set_exp(1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0);
        check_cycle("mrst_c2");
        rst = 1'b1;
        check_cycle("mrst_c3");

        // Load-use, release, then rd = x0.
        ex_mem_ren = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_ren = 1'b1;
        set_exp(1'b1, 1'b0, 32'd0, 4'b0001, 4'b0010, 1'b0);
        check_cycle("lu_hit");
        ex_mem_ren = 1'b0;
        set_exp(1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0);
        check_cycle("lu_release");
        ex_mem_ren = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
        check_cycle("lu_x0");
        ex_rd_addr = 5'd5; id_rs1_addr = 5'd5;
        ex_branch_taken = 1'b1; ex_branch_target = 32'h8000_0040;
        set_exp(1'b0, 1'b1, 32'h8000_0040, 4'b0000, 4'b0011, 1'b0);
        check_cycle("br_over_lu");
        idle_in();

        // Single-cycle vector table, each applied from IDLE.
        for (int i = 0; i < 9; i++) begin
            id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2;
            id_rs1_ren = vecs[i].r1en; id_rs2_ren = vecs[i].r2en;
            ex_rd_addr = vecs[i].rd; ex_mem_ren = vecs[i].load;
            ex_branch_taken = vecs[i].taken; ex_branch_target = vecs[i].tgt;
            ex_mcyc_start = vecs[i].start; mem_wait = vecs[i].mw;
            set_exp(vecs[i].e_pcs, vecs[i].e_red, vecs[i].e_addr, vecs[i].e_st,
                    vecs[i].e_fl, 1'b0);
            check_cycle($sformatf("vec%0d", i));
        end

        // Randomized cycles against the model, perf counters included.
        perf_chk_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0 || $urandom_range(59) == 0) ? 1'b0 : 1'b1;
            id_rs1_addr = 5'($urandom_range(3));
            id_rs2_addr = 5'($urandom_range(3));
            ex_rd_addr = 5'($urandom_range(3));
            id_rs1_ren = 1'($urandom_range(1));
            id_rs2_ren = 1'($urandom_range(1));
            ex_mem_ren = ($urandom_range(2) == 0);
            ex_branch_taken = ($urandom_range(3) == 0);
            ex_branch_target = $urandom;
            ex_mcyc_start = ($urandom_range(9) == 0);
            mem_wait = ($urandom_range(4) == 0);
            model_eval();
            check_cycle($sformatf("rnd%0d", i));
            model_tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage in-order pipeline.
- Drives the per-register `stall`/`flush` controls of the enable-DFF pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), plus PC hold and redirect.
- Resolves load-use hazards, taken-branch redirects, fixed-latency multi-cycle EX ops and memory wait.
- Control outputs are combinational from current state plus inputs, so each pipeline register samples them at the same edge.

Parameters:
- XLEN, 32, PC/target width.
- MCYC_LAT, 4, total stall cycles for a multi-cycle EX op (legal range >= 2).
- CNT_W, $clog2(MCYC_LAT)+1, width of the multi-cycle down-counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- id_rs1_addr  in  5  ID-stage source register 1
- id_rs2_addr  in  5  ID-stage source register 2
- id_rs1_ren  in  1  rs1 is read
- id_rs2_ren  in  1  rs2 is read
- ex_rd_addr  in  5  EX-stage destination register
- ex_mem_ren  in  1  EX-stage instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_branch_target  in  XLEN  redirect target
- ex_mcyc_start  in  1  EX holds a new multi-cycle op (single-cycle pulse)
- mem_wait  in  1  MEM stage waiting on bus
- pc_stall  out  1  hold PC
- pc_redirect  out  1  load PC with pc_redirect_addr
- pc_redirect_addr  out  XLEN  redirect target
- stall  out  4  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB
- flush  out  4  same bit mapping; inserts a bubble
- mcyc_busy  out  1  state is MCYC
- perf_stall_cnt  out  32  feature counter (see Optional Feature)
- perf_flush_cnt  out  32  feature counter

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, cnt=0, perf counters=0.
  - While rst==0, all outputs are forced to 0.
- States:
  - IDLE -> MCYC when ex_mcyc_start=1 and mem_wait=0; cnt loads MCYC_LAT-1.
  - MCYC: cnt decrements every cycle, including cycles with mem_wait=1.
  - MCYC -> IDLE when cnt==1 (the transition takes effect at that edge).
- Load-use hazard: ex_mem_ren=1 and ex_rd_addr!=0 and ((id_rs1_ren and rs1==rd) or (id_rs2_ren and rs2==rd)).
- Output priority, highest first:
  1. mem_wait=1: pc_stall=1, stall=4'b1111, flush=0, pc_redirect=0. Branch stays in EX and re-fires later.
  2. Multi-cycle (IDLE with ex_mcyc_start=1, or MCYC): pc_stall=1, stall=4'b0011, flush=4'b0100. ex_branch_taken is ignored.
  3. Taken branch: pc_redirect=1, pc_redirect_addr=ex_branch_target, flush=4'b0011, stall=0. Overrides a simultaneous load-use.
  4. Load-use: pc_stall=1, stall=4'b0001, flush=4'b0010. Exactly one bubble; releases next cycle because the load has moved to MEM.
  5. Otherwise all outputs are 0.
- pc_redirect_addr is 0 whenever pc_redirect=0.
- Multi-cycle stall covers exactly MCYC_LAT consecutive cycles, counting the start cycle, when mem_wait stays 0. mem_wait extends the freeze but not the count.
- ex_mcyc_start arriving while in MCYC is ignored.
- Reset asserted mid-MCYC: returns to IDLE and releases all stalls on the next cycle.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with pc_stall=1.
  - perf_flush_cnt increments on every cycle with flush!=0.
  - Both are 32-bit and wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared defines package holds:
  - stage index constants (IFID=0, IDEX=1, EXMEM=2, MEMWB=3);
  - the state encoding (IDLE=1'b0, MCYC=1'b1);
  - the register-address width (5).
- One natural sub-module: mcyc_counter, holding cnt and the state flop with load/decrement/done.
- Priority muxing stays in the top module.

Test Plan:
- Reset behaviour: rst=0 for 2 cycles with ex_branch_taken=1, mem_wait=1 -> all outputs 0. After release with idle inputs, outputs stay 0.
- Load-use: ex_mem_ren=1, ex_rd=5, id_rs1=5, ren=1 for 1 cycle -> pc_stall=1, stall=0001, flush=0010. Next cycle (ex_mem_ren=0) all outputs 0. Repeat with ex_rd=0 -> no stall.
- Branch over load-use: taken=1, target=0x8000_0040 plus load-use match -> pc_redirect=1, addr=0x8000_0040, flush=0011, stall=0.
- Multi-cycle, MCYC_LAT=4: ex_mcyc_start pulse -> stall=0011, flush=0100, pc_stall=1 for exactly 4 cycles. mcyc_busy=1 in cycles 2-4, then 0.
- mem_wait during MCYC: mem_wait=1 in cycle 2 for 3 cycles -> stall=1111, flush=0 those cycles. MCYC still ends at cycle 4. Branch raised during mem_wait -> no redirect until mem_wait=0.
- PIPE_HAZARD_PERF_EN defined, after the MCYC test from reset -> perf_stall_cnt=4, perf_flush_cnt=4. Undefined -> both read 0.
